// File: rtl/uart_pkg.sv
// Shared UART constants and helpers, used by both the receive and transmit paths.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int DEFAULT_IDLE_TIMEOUT = 1024;

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head byte.
// Full/empty are derived from the occupancy count rather than from pointer equality.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head_data,
  output logic [occ_width(DEPTH)-1:0] level,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = occ_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]    level_reg, level_next;
  logic [WIDTH-1:0] head_reg;
  logic             push_ok, pop_ok;

  assign empty     = (level_reg == '0);
  assign full      = (level_reg == LW'(DEPTH));
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign level     = level_reg;
  assign head_data = head_reg;

  always_comb begin
    rd_ptr_next = pop_ok ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    level_next  = level_reg;
    case ({push_ok, pop_ok})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  // Storage carries no reset so it can map onto RAM resources.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // The head register looks one step ahead; a byte written into the slot that
  // becomes the head this edge is forwarded straight from push_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      if (level_next != '0) begin
        head_reg <= (push_ok && (wr_ptr_reg == rd_ptr_next)) ? push_data : mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/uart_rx_controller.sv
// Receive-side controller: buffers good bytes for the host, counts parity
// failures, flags overrun and pulses msg_end after an idle gap on the line.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int IDLE_TIMEOUT  = DEFAULT_IDLE_TIMEOUT,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [UART_DATA_WIDTH-1:0]       rx_data,
  input  logic                             rx_valid,
  input  logic                             rx_error,
  output logic [UART_DATA_WIDTH-1:0]       out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [occ_width(FIFO_DEPTH)-1:0] fifo_level,
  output logic                             overrun,
  output logic [ERR_CNT_WIDTH-1:0]         err_count,
  output logic                             msg_end,
  input  logic                             clear_status
);

  localparam int CW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_TIMEOUT - 1);

  logic                     full, empty, push, pop;
  logic                     good_byte, bad_byte, drop_byte;
  logic                     overrun_reg;
  logic [ERR_CNT_WIDTH-1:0] err_count_reg;
  logic [CW-1:0]            idle_cnt_reg;
  logic                     armed_reg, msg_end_reg;

  assign good_byte = rx_valid && !rx_error;
  assign bad_byte  = rx_valid && rx_error;
  assign pop       = out_valid && out_ready;
  assign push      = good_byte && (!full || pop);
  assign drop_byte = good_byte && full && !pop;
  assign out_valid = !empty;

  sync_fifo #(
    .WIDTH(UART_DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(rx_data),
    .pop      (pop),
    .head_data(out_data),
    .level    (fifo_level),
    .full     (full),
    .empty    (empty)
  );

  // A new event in the same cycle as clear_status takes precedence over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_reg   <= 1'b0;
      err_count_reg <= '0;
    end else begin
      if (drop_byte) begin
        overrun_reg <= 1'b1;
      end else if (clear_status) begin
        overrun_reg <= 1'b0;
      end
      if (bad_byte) begin
        if (clear_status) begin
          err_count_reg <= ERR_CNT_WIDTH'(1);
        end else if (err_count_reg != '1) begin
          err_count_reg <= err_count_reg + 1'b1;
        end
      end else if (clear_status) begin
        err_count_reg <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_reg <= '0;
      armed_reg    <= 1'b0;
      msg_end_reg  <= 1'b0;
    end else begin
      msg_end_reg <= 1'b0;
      if (rx_valid) begin
        idle_cnt_reg <= '0;
        armed_reg    <= 1'b1;
      end else if (armed_reg) begin
        if (idle_cnt_reg == IDLE_LAST) begin
          idle_cnt_reg <= '0;
          armed_reg    <= 1'b0;
          msg_end_reg  <= 1'b1;
        end else begin
          idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign overrun   = overrun_reg;
  assign err_count = err_count_reg;
  assign msg_end   = msg_end_reg;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller; a byte scoreboard follows the host handshake.
module tb_uart_rx_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_error = 1'b0;
  logic       out_ready = 1'b0;
  logic       clear_status = 1'b0;

  logic [7:0] a_out_data, b_out_data;
  logic       a_out_valid, b_out_valid;
  logic [2:0] a_fifo_level;
  logic [3:0] b_fifo_level;
  logic       a_overrun, b_overrun;
  logic [7:0] a_err_count;
  logic [1:0] b_err_count;
  logic       a_msg_end, b_msg_end;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_controller #(.FIFO_DEPTH(4), .IDLE_TIMEOUT(16), .ERR_CNT_WIDTH(8)) dut_a (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .fifo_level(a_fifo_level), .overrun(a_overrun), .err_count(a_err_count),
    .msg_end(a_msg_end), .clear_status(clear_status)
  );

  uart_rx_controller #(.FIFO_DEPTH(8), .IDLE_TIMEOUT(16), .ERR_CNT_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .fifo_level(b_fifo_level), .overrun(b_overrun), .err_count(b_err_count),
    .msg_end(b_msg_end), .clear_status(clear_status)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor: inputs only change just after posedge, so at negedge
  // valid&&ready means the head byte is taken at the coming edge.
  always @(negedge clk) begin
    if (a_msg_end) pulses++;
    if (!reset && a_out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_pop", 32'(a_out_data), 32'h100);
      else check("sb_data", 32'(a_out_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] data, input logic err, input logic accept);
    rx_data  = data;
    rx_error = err;
    rx_valid = 1'b1;
    if (accept) exp_q.push_back(data);
    $display("tx byte=0x%02h err=%0b accept=%0b", data, err, accept);
    tick();
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    reset = 1'b0;
    check("rst_out_valid", 32'(a_out_valid), 0);
    check("rst_out_data", 32'(a_out_data), 0);
    check("rst_level", 32'(a_fifo_level), 0);
    check("rst_overrun", 32'(a_overrun), 0);
    check("rst_err", 32'(a_err_count), 0);
    check("rst_msg_end", 32'(a_msg_end), 0);

    // Three good bytes held, then drained in order
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    send(8'h33, 1'b0, 1'b1);
    check("fill3_level", 32'(a_fifo_level), 3);
    check("fill3_head", 32'(a_out_data), 32'h11);
    check("fill3_valid", 32'(a_out_valid), 1);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("drain3_valid", 32'(a_out_valid), 0);
    check("drain3_level", 32'(a_fifo_level), 0);
    check("drain3_sb_empty", 32'(exp_q.size()), 0);

    // Parity errors: counted, never buffered, saturating on the narrow counter
    repeat (3) send(8'hA5, 1'b1, 1'b0);
    check("perr_level", 32'(a_fifo_level), 0);
    check("perr_count3", 32'(a_err_count), 3);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("perr_cleared", 32'(a_err_count), 0);
    repeat (5) send(8'hA5, 1'b1, 1'b0);
    check("perr_count5", 32'(a_err_count), 5);
    check("perr_saturated", 32'(b_err_count), 3);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;

    // Overrun on a full FIFO; push with simultaneous pop is accepted
    send(8'h01, 1'b0, 1'b1);
    send(8'h02, 1'b0, 1'b1);
    send(8'h03, 1'b0, 1'b1);
    send(8'h04, 1'b0, 1'b1);
    check("full_level", 32'(a_fifo_level), 4);
    check("full_no_overrun", 32'(a_overrun), 0);
    send(8'h55, 1'b0, 1'b0);
    check("ovr_flag", 32'(a_overrun), 1);
    check("ovr_level", 32'(a_fifo_level), 4);
    out_ready = 1'b1;
    send(8'h66, 1'b0, 1'b1);
    out_ready = 1'b0;
    check("pushpop_overrun", 32'(a_overrun), 1);
    check("pushpop_level", 32'(a_fifo_level), 4);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    check("ovr_drain_valid", 32'(a_out_valid), 0);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("ovr_cleared", 32'(a_overrun), 0);

    // Event beats clear_status in the same cycle
    send(8'h81, 1'b0, 1'b1);
    send(8'h82, 1'b0, 1'b1);
    send(8'h83, 1'b0, 1'b1);
    send(8'h84, 1'b0, 1'b1);
    clear_status = 1'b1;
    send(8'h77, 1'b0, 1'b0);
    clear_status = 1'b0;
    check("clr_vs_ovr", 32'(a_overrun), 1);
    send(8'hE1, 1'b1, 1'b0);
    clear_status = 1'b1;
    send(8'hE2, 1'b1, 1'b0);
    clear_status = 1'b0;
    check("clr_vs_err", 32'(a_err_count), 1);

    // Reset with two bytes buffered and the timer armed
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    check("pre_rst_level", 32'(a_fifo_level), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("mid_rst_valid", 32'(a_out_valid), 0);
    check("mid_rst_level", 32'(a_fifo_level), 0);
    check("mid_rst_overrun", 32'(a_overrun), 0);
    check("mid_rst_err", 32'(a_err_count), 0);
    pulses = 0;
    repeat (30) tick();
    check("mid_rst_no_pulse", 32'(pulses), 0);

    // Idle timeout: single byte then silence
    pulses = 0;
    send(8'h5A, 1'b0, 1'b1);
    repeat (15) tick();
    check("idle_before", 32'(a_msg_end), 0);
    tick();
    check("idle_fire", 32'(a_msg_end), 1);
    tick();
    check("idle_one_cycle", 32'(a_msg_end), 0);
    repeat (40) tick();
    check("idle_pulse_count", 32'(pulses), 1);

    // Second byte lands on the would-be timeout cycle
    pulses = 0;
    send(8'h5B, 1'b0, 1'b1);
    repeat (15) tick();
    send(8'h5C, 1'b0, 1'b1);
    check("restart_no_fire", 32'(a_msg_end), 0);
    repeat (15) tick();
    check("restart_before", 32'(a_msg_end), 0);
    tick();
    check("restart_fire", 32'(a_msg_end), 1);
    repeat (20) tick();
    check("restart_pulse_count", 32'(pulses), 1);

    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    check("final_valid", 32'(a_out_valid), 0);
    check("final_sb_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
